// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_HALTED = 3'd3,
    ST_ERROR  = 3'd4
  } fetch_state_t;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 16;

endpackage : fetch_pkg

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: requests an instruction at the current PC,
// holds it for issue, pulses the PC advance enable, counts retirements and
// flags a sticky error when memory fails to answer in time.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] pc_value,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        halt,
  output logic        pc_en,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        fetch_err,
  output logic [31:0] instret
);

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

  fetch_state_t state_q, state_d;
  logic [7:0]   timer_q, timer_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instret_q, instret_d;

  // State, timer, held instruction and retirement counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_BOOT;
      timer_q   <= '0;
      instr_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
    end
  end

  // Next-state and output decode; everything inactive unless a state claims it.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    instr_d     = instr_q;
    imem_req    = 1'b0;
    imem_addr   = '0;
    pc_en       = 1'b0;
    instr_valid = 1'b0;
    fetch_err   = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        timer_d = '0;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_value;
        if (imem_ack) begin
          instr_d = imem_rdata;
          timer_d = '0;
          state_d = ST_ISSUE;
        end else if (timer_q == TIMER_LAST) begin
          state_d = ST_ERROR;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      ST_ISSUE: begin
        instr_valid = 1'b1;
        if (stall) begin
          state_d = ST_ISSUE;
        end else if (halt) begin
          state_d = ST_HALTED;
        end else begin
          pc_en   = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      ST_ERROR: begin
        fetch_err = 1'b1;
        state_d   = ST_ERROR;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Retirement counter advances with each PC advance, wrapping naturally.
  always_comb begin
    instret_d = instret_q;
    if (pc_en) begin
      instret_d = instret_q + 32'd1;
    end
  end

  assign instr_out = instr_q;
  assign instret   = instret_q;

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with hand-computed expectations.
module tb_fetch_ctrl;

  logic        clock;
  logic        reset_n;
  logic [31:0] pc_value;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        halt;
  logic        pc_en;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        fetch_err;
  logic [31:0] instret;

  int unsigned total;
  int unsigned bad;

  fetch_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .pc_value   (pc_value),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .halt       (halt),
    .pc_en      (pc_en),
    .instr_out  (instr_out),
    .instr_valid(instr_valid),
    .fetch_err  (fetch_err),
    .instret    (instret)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset_n    = 1'b0;
    pc_value   = 32'h0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    stall      = 1'b0;
    halt       = 1'b0;

    // Reset state
    #1;
    chk("rst_req",     {31'b0, imem_req},    32'h0);
    chk("rst_pcen",    {31'b0, pc_en},       32'h0);
    chk("rst_valid",   {31'b0, instr_valid}, 32'h0);
    chk("rst_err",     {31'b0, fetch_err},   32'h0);
    chk("rst_instret", instret,              32'h0);
    chk("rst_instr",   instr_out,            32'h0);

    // Release reset; BOOT keeps everything quiet
    tick();
    reset_n = 1'b1;
    #1;
    chk("boot_req", {31'b0, imem_req}, 32'h0);

    // First fetch at PC 0 with immediate ack
    tick();
    pc_value   = 32'h0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0013;
    #1;
    chk("f1_req",   {31'b0, imem_req},    32'h1);
    chk("f1_addr",  imem_addr,            32'h0);
    chk("f1_valid", {31'b0, instr_valid}, 32'h0);
    chk("f1_pcen",  {31'b0, pc_en},       32'h0);
    tick();
    imem_ack = 1'b0;
    #1;
    chk("i1_valid", {31'b0, instr_valid}, 32'h1);
    chk("i1_instr", instr_out,            32'h0000_0013);
    chk("i1_pcen",  {31'b0, pc_en},       32'h1);
    chk("i1_req",   {31'b0, imem_req},    32'h0);
    tick();
    #1;
    chk("f2_instret", instret,              32'h1);
    chk("f2_valid",   {31'b0, instr_valid}, 32'h0);
    chk("f2_pcen",    {31'b0, pc_en},       32'h0);
    chk("f2_req",     {31'b0, imem_req},    32'h1);

    // Fetch at PC 4, then stall three cycles in ISSUE with a stray ack
    pc_value   = 32'h4;
    imem_ack   = 1'b1;
    imem_rdata = 32'hABCD_0001;
    #1;
    chk("f2_addr", imem_addr, 32'h4);
    tick();
    stall      = 1'b1;
    imem_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_pcen",  {31'b0, pc_en},       32'h0);
      chk("stall_valid", {31'b0, instr_valid}, 32'h1);
      chk("stall_instr", instr_out,            32'hABCD_0001);
      tick();
    end
    stall    = 1'b0;
    imem_ack = 1'b0;
    #1;
    chk("unstall_pcen",  {31'b0, pc_en}, 32'h1);
    chk("unstall_instr", instr_out,      32'hABCD_0001);
    chk("unstall_cnt",   instret,        32'h1);
    tick();
    #1;
    chk("post_stall_instret", instret,           32'h2);
    chk("post_stall_pcen",    {31'b0, pc_en},    32'h0);

    // halt together with stall holds ISSUE; dropping stall halts
    imem_ack   = 1'b1;
    imem_rdata = 32'h0010_0073;
    tick();
    imem_ack = 1'b0;
    halt     = 1'b1;
    stall    = 1'b1;
    #1;
    chk("hs_pcen", {31'b0, pc_en}, 32'h0);
    tick();
    #1;
    chk("hs_valid", {31'b0, instr_valid}, 32'h1);
    stall = 1'b0;
    #1;
    chk("h_pcen", {31'b0, pc_en}, 32'h0);
    tick();
    imem_ack = 1'b1;
    #1;
    chk("halted_valid",   {31'b0, instr_valid}, 32'h0);
    chk("halted_req",     {31'b0, imem_req},    32'h0);
    chk("halted_pcen",    {31'b0, pc_en},       32'h0);
    chk("halted_instret", instret,              32'h2);
    tick();
    tick();
    #1;
    chk("halted_stay_valid", {31'b0, instr_valid}, 32'h0);
    chk("halted_stay_req",   {31'b0, imem_req},    32'h0);
    chk("halted_stay_cnt",   instret,              32'h2);
    imem_ack = 1'b0;
    halt     = 1'b0;

    // Asynchronous reset mid-FETCH
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    tick();            // BOOT -> FETCH
    pc_value = 32'h100;
    #1;
    chk("arst_pre_req", {31'b0, imem_req}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("arst_req",     {31'b0, imem_req}, 32'h0);
    chk("arst_addr",    imem_addr,         32'h0);
    chk("arst_instret", instret,           32'h0);
    chk("arst_pcen",    {31'b0, pc_en},    32'h0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("arst_boot_req", {31'b0, imem_req}, 32'h0);
    tick();
    #1;
    chk("arst_refetch_req", {31'b0, imem_req}, 32'h1);

    // Timeout: timer 0 here; 15 more silent cycles stay in FETCH, the 16th errors
    for (int i = 0; i < 15; i++) begin
      tick();
    end
    #1;
    chk("to_last_req", {31'b0, imem_req},  32'h1);
    chk("to_last_err", {31'b0, fetch_err}, 32'h0);
    tick();
    #1;
    chk("to_err",  {31'b0, fetch_err}, 32'h1);
    chk("to_req",  {31'b0, imem_req},  32'h0);
    chk("to_pcen", {31'b0, pc_en},     32'h0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    #1;
    chk("late_ack_err",   {31'b0, fetch_err},   32'h1);
    chk("late_ack_valid", {31'b0, instr_valid}, 32'h0);
    chk("late_ack_instr", instr_out,            32'h0);

    // Retirement counter wrap
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    tick();            // FETCH
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    chk("wrap_pre", instret, 32'hFFFF_FFFF);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0001;
    tick();
    imem_ack = 1'b0;
    #1;
    chk("wrap_pcen", {31'b0, pc_en}, 32'h1);
    tick();
    #1;
    chk("wrap_instret", instret, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_fetch_ctrl
